// File: rtl/c4_pkg.sv
// Shared Connect-Four constants, cell/winner codes and grid index helpers.
// Cell (r,c) occupies grid[cell_idx(r,c) -: 2]; row 0 is the bottom row.
package c4_pkg;
    localparam int ROWS       = 6;
    localparam int COLS       = 7;
    localparam int FULL_MOVES = ROWS * COLS;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P0    = 2'b01;
    localparam logic [1:0] CELL_P1    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [2:0] {IDLE, PLACE, CHK_H, CHK_V, CHK_D1, CHK_D2} state_e;

    function automatic logic [6:0] cell_idx(input int r, input int c);
        return 7'(13 - 2 * c + 14 * r);
    endfunction

    function automatic logic [2:0] opt_col(input logic [6:0] opt);
        return 3'((13 - int'(opt % 7'd14)) / 2);
    endfunction

    function automatic logic [3:0] opt_row(input logic [6:0] opt);
        return 4'(opt / 7'd14);
    endfunction

    function automatic logic [2:0] col_count(input logic [20:0] counts, input logic [2:0] c);
        logic [23:0] ext;
        ext = {3'b000, counts};
        return ext[3 * c +: 3];
    endfunction

    function automatic logic in_board(input int r, input int c);
        return (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    endfunction
endpackage

// File: rtl/c4_run_count.sv
// Combinational run length through the placed cell along one direction,
// looking up to three cells each way and stopping at the board edge.
module c4_run_count
    import c4_pkg::*;
(
    input  logic [83:0]       grid_i,
    input  logic [2:0]        row_i,
    input  logic [2:0]        col_i,
    input  logic signed [1:0] dr_i,
    input  logic signed [1:0] dc_i,
    input  logic [1:0]        code_i,
    output logic [2:0]        run_o
);
    always_comb begin
        int   rr;
        int   cc;
        logic fwd_go;
        logic bwd_go;
        run_o  = 3'd1;
        rr     = 0;
        cc     = 0;
        fwd_go = 1'b1;
        bwd_go = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rr = int'(row_i) + k * int'(dr_i);
            cc = int'(col_i) + k * int'(dc_i);
            if (fwd_go && in_board(rr, cc) && grid_i[cell_idx(rr, cc) -: 2] == code_i)
                run_o = run_o + 3'd1;
            else
                fwd_go = 1'b0;
        end
        for (int k = 1; k <= 3; k++) begin
            rr = int'(row_i) - k * int'(dr_i);
            cc = int'(col_i) - k * int'(dc_i);
            if (bwd_go && in_board(rr, cc) && grid_i[cell_idx(rr, cc) -: 2] == code_i)
                run_o = run_o + 3'd1;
            else
                bwd_go = 1'b0;
        end
    end
endmodule

// File: rtl/board_state.sv
// Authoritative Connect-Four board: accepts human drops and AI moves in IDLE,
// places the piece, then checks one line direction per cycle for a win or draw.
module board_state
    import c4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sw,
    input  logic [2:0]  col_sel,
    input  logic        drop,
    input  logic        restart,
    input  logic [6:0]  ai_opt,
    input  logic        ai_move,
    output logic [83:0] grid,
    output logic [20:0] column_counts,
    output logic        player,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [5:0]  move_count
);
    state_e      state_q;
    logic [83:0] grid_q;
    logic [20:0] counts_q;
    logic        player_q;
    logic [1:0]  winner_q;
    logic [5:0]  moves_q;
    logic [2:0]  col_q;
    logic [2:0]  row_q;
    logic        win_q;

    logic              accept_d;
    logic [2:0]        tgt_col_d;
    logic [2:0]        ai_col;
    logic [3:0]        ai_row;
    logic              ai_ok;
    logic              fb_found;
    logic [2:0]        fb_col;
    logic [2:0]        cur_row;
    logic [1:0]        code;
    logic signed [1:0] dr;
    logic signed [1:0] dc;
    logic [2:0]        run_len;

    assign code    = player_q ? CELL_P1 : CELL_P0;
    assign cur_row = col_count(counts_q, col_q);

    // Request arbitration: whose turn it is decides which request is even looked at.
    always_comb begin
        ai_col    = opt_col(ai_opt);
        ai_row    = opt_row(ai_opt);
        fb_found  = 1'b0;
        fb_col    = 3'd0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_count(counts_q, 3'(c)) < 3'(ROWS)) begin
                fb_found = 1'b1;
                fb_col   = 3'(c);
            end
        end
        ai_ok = ai_opt[0] && (ai_col < 3'(COLS)) && (ai_row < 4'(ROWS))
                && (ai_row == {1'b0, col_count(counts_q, ai_col)});
        accept_d  = 1'b0;
        tgt_col_d = col_sel;
        if (state_q == IDLE && winner_q == WIN_NONE) begin
            if (player_q && sw) begin
                if (ai_move && (ai_ok || fb_found)) begin
                    accept_d  = 1'b1;
                    tgt_col_d = ai_ok ? ai_col : fb_col;
                end
            end else if (drop && col_sel < 3'(COLS) && col_count(counts_q, col_sel) < 3'(ROWS)) begin
                accept_d = 1'b1;
            end
        end
    end

    always_comb begin
        dr = 2'sd1;
        dc = 2'sd0;
        case (state_q)
            CHK_H:   begin dr = 2'sd0; dc = 2'sd1;  end
            CHK_D1:  begin dr = 2'sd1; dc = 2'sd1;  end
            CHK_D2:  begin dr = 2'sd1; dc = -2'sd1; end
            default: begin dr = 2'sd1; dc = 2'sd0;  end
        endcase
    end

    c4_run_count u_run (
        .grid_i (grid_q),
        .row_i  (row_q),
        .col_i  (col_q),
        .dr_i   (dr),
        .dc_i   (dc),
        .code_i (code),
        .run_o  (run_len)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            counts_q <= '0;
            player_q <= 1'b0;
            winner_q <= WIN_NONE;
            moves_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= 1'b0;
        end else if (restart) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            counts_q <= '0;
            player_q <= 1'b0;
            winner_q <= WIN_NONE;
            moves_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            win_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        col_q   <= tgt_col_d;
                        win_q   <= 1'b0;
                        state_q <= PLACE;
                    end
                end
                PLACE: begin
                    row_q    <= cur_row;
                    grid_q   <= grid_q | (84'(code) << (cell_idx(int'(cur_row), int'(col_q)) - 7'd1));
                    counts_q <= counts_q + (21'd1 << (3 * int'(col_q)));
                    moves_q  <= moves_q + 6'd1;
                    state_q  <= CHK_H;
                end
                CHK_H: begin
                    win_q   <= win_q | (run_len >= 3'd4);
                    state_q <= CHK_V;
                end
                CHK_V: begin
                    win_q   <= win_q | (run_len >= 3'd4);
                    state_q <= CHK_D1;
                end
                CHK_D1: begin
                    win_q   <= win_q | (run_len >= 3'd4);
                    state_q <= CHK_D2;
                end
                CHK_D2: begin
                    // Win beats draw: a 42nd piece completing a line is still a win.
                    if (win_q || run_len >= 3'd4)
                        winner_q <= code;
                    else if (moves_q == 6'(FULL_MOVES))
                        winner_q <= WIN_DRAW;
                    else
                        player_q <= ~player_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grid          = grid_q;
    assign column_counts = counts_q;
    assign player        = player_q;
    assign winner        = winner_q;
    assign game_over     = (winner_q != WIN_NONE);
    assign move_count    = moves_q;
endmodule
